// File: rtl/bp_cache_req_arbiter.sv
// Round-robin arbiter that puts N cache-engine miss requests onto one LCE request port.
// It also tracks the transaction owner, routes fill packets and completions, and runs a sticky timeout watchdog.
module bp_cache_req_arbiter #(
    parameter int num_caches_p     = 2,
    parameter int req_width_p      = 128,
    parameter int metadata_width_p = 8,
    parameter int timeout_cycles_p = 4096,
    localparam int id_width_lp     = (num_caches_p > 1) ? $clog2(num_caches_p) : 1
) (
    input  logic                                     clk_i,
    input  logic                                     reset_i,
    input  logic [num_caches_p*req_width_p-1:0]      cache_req_i,
    input  logic [num_caches_p-1:0]                  cache_req_v_i,
    output logic [num_caches_p-1:0]                  cache_req_ready_o,
    input  logic [num_caches_p*metadata_width_p-1:0] cache_req_metadata_i,
    input  logic [num_caches_p-1:0]                  cache_req_metadata_v_i,
    output logic [num_caches_p-1:0]                  cache_req_complete_o,
    output logic [req_width_p-1:0]                   lce_req_o,
    output logic                                     lce_req_v_o,
    input  logic                                     lce_req_ready_i,
    output logic [metadata_width_p-1:0]              lce_req_metadata_o,
    output logic                                     lce_req_metadata_v_o,
    input  logic                                     lce_req_complete_i,
    input  logic [2:0]                               fill_pkt_v_i,
    output logic [2:0]                               fill_pkt_ready_o,
    output logic [num_caches_p*3-1:0]                fill_pkt_v_o,
    input  logic [num_caches_p*3-1:0]                fill_pkt_ready_i,
    output logic [id_width_lp-1:0]                   owner_o,
    output logic                                     busy_o,
    output logic                                     timeout_o
);

    localparam bit watchdog_en_lp  = (timeout_cycles_p > 0);
    localparam int timer_width_lp  = watchdog_en_lp ? $clog2(timeout_cycles_p + 1) : 1;
    localparam logic [timer_width_lp-1:0] timer_max_lp = timer_width_lp'(timeout_cycles_p);
    localparam logic [id_width_lp-1:0]    last_id_lp   = id_width_lp'(num_caches_p - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                    state_q;
    logic [id_width_lp-1:0]    owner_q;
    logic [id_width_lp-1:0]    rr_ptr_q;
    logic [timer_width_lp-1:0] timer_q;
    logic                      meta_sent_q;
    logic                      timeout_q;

    logic [id_width_lp-1:0]    winner;
    logic                      found;
    logic                      any_v;
    logic                      meta_v_sel;
    int                        scan_idx;

    assign any_v = |cache_req_v_i;

    // Rotating-priority scan: the first valid channel at or after rr_ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        winner   = rr_ptr_q;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < num_caches_p; i++) begin
            scan_idx = int'(rr_ptr_q) + i;
            if (scan_idx >= num_caches_p) scan_idx = scan_idx - num_caches_p;
            for (int k = 0; k < num_caches_p; k++) begin
                if (!found && scan_idx == k && cache_req_v_i[k]) begin
                    winner = id_width_lp'(k);
                    found  = 1'b1;
                end
            end
        end
    end

    // Request, metadata, completion and fill steering. Handshake outputs are forced low while reset is asserted.
    always_comb begin
        lce_req_o            = '0;
        cache_req_ready_o    = '0;
        cache_req_complete_o = '0;
        lce_req_metadata_o   = '0;
        meta_v_sel           = 1'b0;
        fill_pkt_v_o         = '0;
        fill_pkt_ready_o     = '0;
        for (int k = 0; k < num_caches_p; k++) begin
            if (winner == id_width_lp'(k)) begin
                lce_req_o            = cache_req_i[k*req_width_p +: req_width_p];
                cache_req_ready_o[k] = reset_i && (state_q == IDLE) && lce_req_ready_i;
            end
            if (owner_q == id_width_lp'(k)) begin
                lce_req_metadata_o      = cache_req_metadata_i[k*metadata_width_p +: metadata_width_p];
                meta_v_sel              = cache_req_metadata_v_i[k];
                cache_req_complete_o[k] = (state_q == BUSY) && lce_req_complete_i;
                if (reset_i) begin
                    fill_pkt_v_o[k*3 +: 3] = fill_pkt_v_i;
                    fill_pkt_ready_o       = fill_pkt_ready_i[k*3 +: 3];
                end
            end
        end
    end

    assign lce_req_v_o          = reset_i && (state_q == IDLE) && any_v;
    assign lce_req_metadata_v_o = (state_q == BUSY) && meta_v_sel && !meta_sent_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            meta_sent_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments, so every branch here reads the values from before this edge.
            case (state_q)
                IDLE: begin
                    if (any_v && lce_req_ready_i) begin
                        owner_q  <= winner;
                        rr_ptr_q <= (winner == last_id_lp) ? '0 : winner + 1'b1;
                        timer_q  <= '0;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (lce_req_metadata_v_o) meta_sent_q <= 1'b1;
                    // The watchdog only observes. The flag stays set until reset, and the FSM keeps running.
                    if (watchdog_en_lp && timer_q != timer_max_lp) begin
                        timer_q <= timer_q + 1'b1;
                        if (timer_q + 1'b1 == timer_max_lp) timeout_q <= 1'b1;
                    end
                    if (lce_req_complete_i) begin
                        meta_sent_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign owner_o   = owner_q;
    assign busy_o    = (state_q == BUSY);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// Directed bench for bp_cache_req_arbiter.
// It uses two instances: N=2 with a 16-cycle watchdog, and N=4 with the watchdog disabled.
module tb_bp_cache_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // N=2, timeout 16
    logic [31:0] req2;
    logic [1:0]  req_v2, rdy2, meta_v2, cmpl2;
    logic [15:0] meta2;
    logic [15:0] lreq2;
    logic        lv2, lrdy2, lmv2, lcomp2, busy2, to2;
    logic [7:0]  lmeta2;
    logic [2:0]  fv_i2, frdy_o2;
    logic [5:0]  fv_o2, frdy_i2;
    logic [0:0]  owner2;

    // N=4, watchdog disabled
    logic [63:0] req4;
    logic [3:0]  req_v4, rdy4, meta_v4, cmpl4;
    logic [31:0] meta4;
    logic [15:0] lreq4;
    logic        lv4, lrdy4, lmv4, lcomp4, busy4, to4;
    logic [7:0]  lmeta4;
    logic [2:0]  fv_i4, frdy_o4;
    logic [11:0] fv_o4, frdy_i4;
    logic [1:0]  owner4;

    bp_cache_req_arbiter #(
        .num_caches_p(2), .req_width_p(16), .metadata_width_p(8), .timeout_cycles_p(16)
    ) u_dut2 (
        .clk_i(clk), .reset_i(reset_n),
        .cache_req_i(req2), .cache_req_v_i(req_v2), .cache_req_ready_o(rdy2),
        .cache_req_metadata_i(meta2), .cache_req_metadata_v_i(meta_v2),
        .cache_req_complete_o(cmpl2),
        .lce_req_o(lreq2), .lce_req_v_o(lv2), .lce_req_ready_i(lrdy2),
        .lce_req_metadata_o(lmeta2), .lce_req_metadata_v_o(lmv2),
        .lce_req_complete_i(lcomp2),
        .fill_pkt_v_i(fv_i2), .fill_pkt_ready_o(frdy_o2),
        .fill_pkt_v_o(fv_o2), .fill_pkt_ready_i(frdy_i2),
        .owner_o(owner2), .busy_o(busy2), .timeout_o(to2)
    );

    bp_cache_req_arbiter #(
        .num_caches_p(4), .req_width_p(16), .metadata_width_p(8), .timeout_cycles_p(0)
    ) u_dut4 (
        .clk_i(clk), .reset_i(reset_n),
        .cache_req_i(req4), .cache_req_v_i(req_v4), .cache_req_ready_o(rdy4),
        .cache_req_metadata_i(meta4), .cache_req_metadata_v_i(meta_v4),
        .cache_req_complete_o(cmpl4),
        .lce_req_o(lreq4), .lce_req_v_o(lv4), .lce_req_ready_i(lrdy4),
        .lce_req_metadata_o(lmeta4), .lce_req_metadata_v_o(lmv4),
        .lce_req_complete_i(lcomp4),
        .fill_pkt_v_i(fv_i4), .fill_pkt_ready_o(frdy_o4),
        .fill_pkt_v_o(fv_o4), .fill_pkt_ready_i(frdy_i4),
        .owner_o(owner4), .busy_o(busy4), .timeout_o(to4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [5];
        int g;
        order = '{0, 1, 2, 3, 0};

        // Reset is held while requests and fills are already active.
        reset_n = 1'b0;
        req2 = {16'hBBBB, 16'hAAAA}; req_v2 = 2'b11; lrdy2 = 1'b1;
        meta2 = '0; meta_v2 = '0; lcomp2 = 1'b0; fv_i2 = 3'b111; frdy_i2 = 6'b111111;
        req4 = {16'hA003, 16'hA002, 16'hA001, 16'hA000}; req_v4 = '0; lrdy4 = 1'b0;
        meta4 = {8'h44, 8'h33, 8'h22, 8'h11}; meta_v4 = '0; lcomp4 = 1'b0;
        fv_i4 = '0; frdy_i4 = '0;
        tick(); tick();
        check("rst_lce_v", lv2, 0);
        check("rst_ready", rdy2, 0);
        check("rst_busy", busy2, 0);
        check("rst_owner", owner2, 0);
        check("rst_timeout", to2, 0);
        check("rst_fill_v", fv_o2, 0);
        check("rst_fill_rdy", frdy_o2, 0);

        fv_i2 = 3'b000; frdy_i2 = 6'b100_011;
        #2 reset_n = 1'b1;
        #1;

        // With both channels valid and rr_ptr at 0, cache0 wins.
        check("n2_lce_v", lv2, 1);
        check("n2_req_c0", lreq2, 16'hAAAA);
        check("n2_ready_c0", rdy2, 2'b01);
        tick();
        check("n2_busy", busy2, 1);
        check("n2_owner0", owner2, 0);
        check("n2_busy_ready", rdy2, 0);
        check("n2_busy_lce_v", lv2, 0);
        req_v2 = 2'b10; lcomp2 = 1'b1; #1;
        check("n2_cmpl_c0", cmpl2, 2'b01);
        tick(); lcomp2 = 1'b0; #1;
        check("n2_idle", busy2, 0);
        check("n2_cmpl_pulse", cmpl2, 0);
        check("n2_req_c1", lreq2, 16'hBBBB);
        check("n2_ready_c1", rdy2, 2'b10);
        tick();
        check("n2_owner1", owner2, 1);
        req_v2 = 2'b00;

        // Fill routing to owner 1.
        fv_i2 = 3'b101; #1;
        check("fill_v_busy", fv_o2, 6'b101_000);
        check("fill_rdy_busy", frdy_o2, 3'b100);

        // The watchdog fires once the timer reaches 16, i.e. 16 edges after the grant.
        repeat (15) tick();
        check("wd_before", to2, 0);
        tick();
        check("wd_fire", to2, 1);
        lcomp2 = 1'b1; #1;
        check("n2_cmpl_c1", cmpl2, 2'b10);
        tick(); lcomp2 = 1'b0; #1;
        check("n2_idle2", busy2, 0);
        check("wd_sticky", to2, 1);
        check("fill_v_idle", fv_o2, 6'b101_000);
        check("fill_rdy_idle", frdy_o2, 3'b100);

        // A completion that arrives while IDLE is ignored.
        lcomp2 = 1'b1; #1;
        check("idle_cmpl_ign", cmpl2, 0);
        tick(); lcomp2 = 1'b0; #1;
        check("idle_cmpl_state", busy2, 0);

        // rr_ptr has wrapped back to 0, so cache0 wins again.
        req_v2 = 2'b11; #1;
        check("n2_wrap_ready", rdy2, 2'b01);
        check("n2_wrap_req", lreq2, 16'hAAAA);
        tick(); req_v2 = 2'b00;
        check("n2_wrap_busy", busy2, 1);
        fv_i2 = 3'b111; #1;
        check("fill_v_owner0", fv_o2, 6'b000_111);

        // N=4: all requesters held valid; completion 2 cycles after each grant.
        req_v4 = 4'hF; lrdy4 = 1'b1; #1;
        for (int n = 0; n < 5; n++) begin
            g = order[n];
            check("n4_ready", rdy4, 64'(1) << g);
            check("n4_req", lreq4, 64'h0A000 + 64'(g));
            tick();
            check("n4_busy", busy4, 1);
            check("n4_owner", owner4, 64'(g));
            check("n4_busy_ready", rdy4, 0);
            tick(); lcomp4 = 1'b1; #1;
            check("n4_cmpl", cmpl4, 64'(1) << g);
            tick(); lcomp4 = 1'b0; #1;
            check("n4_cmpl_pulse", cmpl4, 0);
            check("n4_idle", busy4, 0);
        end

        // Metadata: owner 2 forwards exactly one beat, and non-owners are ignored.
        req_v4 = 4'b0100; #1;
        check("n4_ready_c2", rdy4, 4'b0100);
        check("n4_req_c2", lreq4, 16'hA002);
        tick(); req_v4 = 4'b0000;
        check("n4_owner2", owner4, 2);
        meta_v4 = 4'b0001; #1;
        check("meta_nonowner", lmv4, 0);
        meta_v4 = 4'b0101; #1;
        check("meta_v_beat", lmv4, 1);
        check("meta_data", lmeta4, 8'h33);
        tick();
        check("meta_v_once1", lmv4, 0);
        tick();
        check("meta_v_once2", lmv4, 0);
        meta_v4 = 4'b0000;

        // With the watchdog disabled, a long BUSY never raises timeout.
        repeat (20) tick();
        check("wd_off", to4, 0);
        check("wd_off_busy", busy4, 1);
        lcomp4 = 1'b1;
        tick(); lcomp4 = 1'b0; #1;
        check("n4_final_idle", busy4, 0);

        // Asynchronous reset mid-BUSY on dut2. Its timeout has already fired by now.
        check("pre_rst_busy", busy2, 1);
        check("pre_rst_to", to2, 1);
        req_v2 = 2'b11;
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", busy2, 0);
        check("arst_owner", owner2, 0);
        check("arst_to", to2, 0);
        check("arst_lce_v", lv2, 0);
        check("arst_ready", rdy2, 0);
        check("arst_fill_v", fv_o2, 0);
        check("arst_fill_rdy", frdy_o2, 0);

        req_v2 = 2'b10;
        tick();
        reset_n = 1'b1; #1;
        check("post_rst_c1", rdy2, 2'b10);
        check("post_rst_req1", lreq2, 16'hBBBB);
        req_v2 = 2'b11; #1;
        check("post_rst_c0", rdy2, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
